fir_complex_ctrl: RTL and testbench

//  Sequencer for a time-shared complex FIR datapath (single complex MAC + history RAM + coeff ROM).

---
 rtl/fir_complex_pkg.sv | 22 ++
 rtl/fir_hist_addr_gen.sv | 48 ++++
 rtl/fir_complex_ctrl.sv | 177 +++++++++++++++++
 tb/tb_fir_complex_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_complex_pkg.sv
// Shared types and default sizing for the complex FIR controller, datapath and top.
package fir_complex_pkg;

    typedef enum logic [2:0] {
        S_INIT,
        S_LOAD,
        S_MAC,
        S_DRAIN,
        S_WRITE
    } ctrl_state_e;

    localparam int unsigned DEF_NUM_TAPS   = 20;
    localparam int unsigned DEF_DECIM      = 1;
    localparam int unsigned DEF_HIST_DEPTH = 32;
    localparam int unsigned DEF_MAC_LAT    = 2;

    // Larger of two sizes; used to dimension the shared phase counter.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fir_hist_addr_gen.sv
// History RAM addressing: circular write pointer, latch of the newest written slot, and the
// per-tap read address (newest - tap) wrapping modulo HIST_DEPTH by power-of-2 truncation.
module fir_hist_addr_gen
    import fir_complex_pkg::*;
#(
    parameter int unsigned HIST_DEPTH = DEF_HIST_DEPTH,
    parameter int unsigned ADDR_W     = $clog2(HIST_DEPTH),
    parameter int unsigned TAP_W      = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pop_i,
    input  logic [TAP_W-1:0]  tap_i,
    output logic [ADDR_W-1:0] wr_ptr_o,
    output logic [ADDR_W-1:0] rd_addr_o
);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] newest_q, newest_d;

    // Advance the write pointer on every accepted pair and remember where it landed.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        newest_d = newest_q;
        if (pop_i) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            newest_d = wr_ptr_q;
        end
    end

    // Pointer registers, synchronous reset back to slot 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            newest_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            newest_q <= newest_d;
        end
    end

    // Tap k reads k samples back from the newest one; subtraction wraps naturally.
    always_comb begin
        wr_ptr_o  = wr_ptr_q;
        rd_addr_o = newest_q - ADDR_W'(tap_i);
    end

endmodule

// File: rtl/fir_complex_ctrl.sv
// Sequencer for a time-shared complex FIR: zero the history, load DECIM I/Q pairs, run
// NUM_TAPS MAC cycles, wait out the MAC pipeline, then push one real/imag result pair.
module fir_complex_ctrl
    import fir_complex_pkg::*;
#(
    parameter int unsigned NUM_TAPS   = DEF_NUM_TAPS,
    parameter int unsigned DECIM      = DEF_DECIM,
    parameter int unsigned HIST_DEPTH = DEF_HIST_DEPTH,
    parameter int unsigned MAC_LAT    = DEF_MAC_LAT,
    parameter int unsigned ADDR_W     = $clog2(HIST_DEPTH),
    parameter int unsigned TAP_W      = $clog2(NUM_TAPS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_empty_i,
    input  logic              q_empty_i,
    output logic              i_rd_en_o,
    output logic              q_rd_en_o,
    output logic              hist_wr_en_o,
    output logic              hist_zero_o,
    output logic [ADDR_W-1:0] hist_wr_addr_o,
    output logic [ADDR_W-1:0] hist_rd_addr_o,
    output logic [TAP_W-1:0]  tap_addr_o,
    output logic              mac_en_o,
    output logic              mac_clr_o,
    output logic              mac_last_o,
    input  logic              real_full_i,
    input  logic              imag_full_i,
    output logic              real_wr_en_o,
    output logic              imag_wr_en_o,
    output logic              busy_o,
    output logic [15:0]       out_count_o
);

    // One counter serves INIT, LOAD, MAC and DRAIN, so size it for the longest phase.
    localparam int unsigned CNT_MAX = max_u(max_u(HIST_DEPTH, DECIM), max_u(NUM_TAPS, MAC_LAT));
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    ctrl_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       out_count_q, out_count_d;
    logic              pop;
    logic              push;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_addr;

    fir_hist_addr_gen #(
        .HIST_DEPTH (HIST_DEPTH),
        .ADDR_W     (ADDR_W),
        .TAP_W      (TAP_W)
    ) u_addr_gen (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .pop_i     (pop),
        .tap_i     (cnt_q[TAP_W-1:0]),
        .wr_ptr_o  (wr_ptr),
        .rd_addr_o (rd_addr)
    );

    // Next-state and output decode. Reset forces every output low in the reset cycle itself,
    // so an output in progress is dropped without a stray strobe.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        out_count_d    = out_count_q;
        pop            = 1'b0;
        push           = 1'b0;
        i_rd_en_o      = 1'b0;
        q_rd_en_o      = 1'b0;
        hist_wr_en_o   = 1'b0;
        hist_zero_o    = 1'b0;
        hist_wr_addr_o = '0;
        hist_rd_addr_o = '0;
        tap_addr_o     = '0;
        mac_en_o       = 1'b0;
        mac_clr_o      = 1'b0;
        mac_last_o     = 1'b0;
        real_wr_en_o   = 1'b0;
        imag_wr_en_o   = 1'b0;
        busy_o         = 1'b0;

        if (!rst_i) begin
            unique case (state_q)
                S_INIT: begin
                    busy_o         = 1'b1;
                    hist_wr_en_o   = 1'b1;
                    hist_zero_o    = 1'b1;
                    hist_wr_addr_o = cnt_q[ADDR_W-1:0];
                    if (cnt_q == CNT_W'(HIST_DEPTH - 1)) begin
                        state_d = S_LOAD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                S_LOAD: begin
                    // Both FIFOs must offer data; a lone non-empty FIFO is never popped.
                    pop            = !i_empty_i && !q_empty_i;
                    i_rd_en_o      = pop;
                    q_rd_en_o      = pop;
                    hist_wr_en_o   = pop;
                    hist_wr_addr_o = wr_ptr;
                    busy_o         = pop;
                    if (pop) begin
                        if (cnt_q == CNT_W'(DECIM - 1)) begin
                            state_d = S_MAC;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end

                S_MAC: begin
                    busy_o         = 1'b1;
                    mac_en_o       = 1'b1;
                    tap_addr_o     = cnt_q[TAP_W-1:0];
                    hist_rd_addr_o = rd_addr;
                    mac_clr_o      = (cnt_q == '0);
                    mac_last_o     = (cnt_q == CNT_W'(NUM_TAPS - 1));
                    if (cnt_q == CNT_W'(NUM_TAPS - 1)) begin
                        state_d = S_DRAIN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                S_DRAIN: begin
                    busy_o = 1'b1;
                    if (cnt_q == CNT_W'(MAC_LAT - 1)) begin
                        state_d = S_WRITE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                S_WRITE: begin
                    busy_o       = 1'b1;
                    push         = !real_full_i && !imag_full_i;
                    real_wr_en_o = push;
                    imag_wr_en_o = push;
                    if (push) begin
                        out_count_d = out_count_q + 16'd1;
                        state_d     = S_LOAD;
                    end
                end

                default: begin
                    state_d = S_INIT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, phase counter and output counter; reset restarts history zeroing.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_INIT;
            cnt_q       <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_count_q <= out_count_d;
        end
    end

    // Output count is a plain register view.
    always_comb begin
        out_count_o = out_count_q;
    end

endmodule

// File: tb/tb_fir_complex_ctrl.sv
// Scoreboard bench: random I/Q samples feed a FIR reference model that queues expected results;
// a negedge monitor models FIFOs, history RAM and the complex MAC from the DUT strobes and
// compares each pushed result and the per-cycle control behaviour.
module tb_fir_complex_ctrl;

    localparam int NT = 20;
    localparam int DEC = 1;
    localparam int HD = 32;
    localparam int ML = 2;
    localparam int AW = 5;
    localparam int TW = 5;

    typedef struct {
        longint re;
        longint im;
    } cpx_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_empty = 1'b1;
    logic          q_empty = 1'b1;
    logic          real_full = 1'b0;
    logic          imag_full = 1'b0;
    logic          i_rd_en, q_rd_en, hist_wr_en, hist_zero;
    logic [AW-1:0] hist_wr_addr, hist_rd_addr;
    logic [TW-1:0] tap_addr;
    logic          mac_en, mac_clr, mac_last;
    logic          real_wr_en, imag_wr_en, busy;
    logic [15:0]   out_count;

    fir_complex_ctrl #(
        .NUM_TAPS   (NT),
        .DECIM      (DEC),
        .HIST_DEPTH (HD),
        .MAC_LAT    (ML)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .i_empty_i      (i_empty),
        .q_empty_i      (q_empty),
        .i_rd_en_o      (i_rd_en),
        .q_rd_en_o      (q_rd_en),
        .hist_wr_en_o   (hist_wr_en),
        .hist_zero_o    (hist_zero),
        .hist_wr_addr_o (hist_wr_addr),
        .hist_rd_addr_o (hist_rd_addr),
        .tap_addr_o     (tap_addr),
        .mac_en_o       (mac_en),
        .mac_clr_o      (mac_clr),
        .mac_last_o     (mac_last),
        .real_full_i    (real_full),
        .imag_full_i    (imag_full),
        .real_wr_en_o   (real_wr_en),
        .imag_wr_en_o   (imag_wr_en),
        .busy_o         (busy),
        .out_count_o    (out_count)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Stimulus side: FIFO contents, gating, sample history and expected results.
    int   iq[$];
    int   qq[$];
    int   xi[$];
    int   xq[$];
    cpx_t exp_q[$];
    bit   i_allow = 1'b1;
    bit   q_allow = 1'b1;
    int   cre[NT];
    int   cim[NT];

    // Monitor side: datapath model and event bookkeeping.
    longint h_i[HD];
    longint h_q[HD];
    longint acc_re = 0, acc_im = 0, res_re = 0, res_im = 0;
    int     mac_k = 0, load_ptr = 0, newest = 0, zero_cnt = 0;
    int     wr_cnt = 0, pop_cnt = 0, cyc = 0;
    int     last_pop_t = 0, last_wr_t = 0, last_mac_t = 0;
    int     rd_log[$];
    bit     post_rst = 1'b0;

    task automatic chk(input string name, input longint act, input longint req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic upd();
        i_empty = !(iq.size() > 0 && i_allow);
        q_empty = !(qq.size() > 0 && q_allow);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        upd();
    endtask

    // Expected output for the newest sample: sum of c[k] * x[n-k], zero before the first sample.
    function automatic void add_expect();
        int   n;
        cpx_t y;
        n = xi.size() - 1;
        y.re = 0;
        y.im = 0;
        for (int k = 0; k < NT; k++) begin
            if (n - k >= 0) begin
                y.re += longint'(cre[k]) * xi[n-k] - longint'(cim[k]) * xq[n-k];
                y.im += longint'(cre[k]) * xq[n-k] + longint'(cim[k]) * xi[n-k];
            end
        end
        exp_q.push_back(y);
    endfunction

    task automatic push_pair();
        int a, b;
        a = int'($urandom_range(0, 2047)) - 1024;
        b = int'($urandom_range(0, 2047)) - 1024;
        iq.push_back(a);
        qq.push_back(b);
        xi.push_back(a);
        xq.push_back(b);
        if ((xi.size() % DEC) == 0) add_expect();
        upd();
    endtask

    task automatic flush();
        iq.delete();
        qq.delete();
        xi.delete();
        xq.delete();
        exp_q.delete();
        upd();
    endtask

    task automatic wait_writes(input int target, input int budget, input string nm);
        int n = 0;
        while (wr_cnt < target && n < budget) begin
            tick();
            n++;
        end
        chk(nm, longint'(wr_cnt >= target), 1);
    endtask

    // Monitor: sample everything mid-cycle, away from the active edge.
    always @(negedge clk) begin
        logic [5:0] viol;
        longint     pr, pi, ci, cq;
        int         a;
        cpx_t       e;
        cyc++;
        if (rst) begin
            chk("reset_strobes", {i_rd_en, q_rd_en, hist_wr_en, mac_en, real_wr_en, imag_wr_en, busy}, 0);
            zero_cnt = 0;
            load_ptr = 0;
            newest   = 0;
            mac_k    = 0;
            wr_cnt   = 0;
            post_rst = 1'b1;
        end else begin
            if (post_rst) chk("post_reset_strobes", {i_rd_en, q_rd_en, mac_en, real_wr_en, imag_wr_en}, 0);
            post_rst = 1'b0;
            viol = {i_rd_en != q_rd_en,
                    real_wr_en != imag_wr_en,
                    hist_wr_en && mac_en,
                    i_rd_en && (i_empty || q_empty),
                    real_wr_en && (real_full || imag_full),
                    hist_zero && !hist_wr_en};
            chk("invariants", viol, 0);

            if (hist_wr_en) begin
                a = int'(hist_wr_addr);
                if (hist_zero) begin
                    chk("init_addr", a, zero_cnt % HD);
                    zero_cnt++;
                    h_i[a] = 0;
                    h_q[a] = 0;
                end else begin
                    chk("load_addr", a, load_ptr);
                    chk("wr_with_pop", i_rd_en, 1);
                    h_i[a]   = (iq.size() > 0) ? iq[0] : 0;
                    h_q[a]   = (qq.size() > 0) ? qq[0] : 0;
                    newest   = load_ptr;
                    load_ptr = (load_ptr + 1) % HD;
                end
            end
            if (i_rd_en) begin
                pop_cnt++;
                last_pop_t = cyc;
                if (iq.size() > 0) void'(iq.pop_front());
                if (qq.size() > 0) void'(qq.pop_front());
            end

            if (mac_en) begin
                chk("tap_addr", tap_addr, mac_k);
                chk("rd_addr", hist_rd_addr, (newest + HD - mac_k) % HD);
                chk("mac_clr", mac_clr, longint'(mac_k == 0));
                chk("mac_last", mac_last, longint'(mac_k == NT - 1));
                rd_log.push_back(int'(hist_rd_addr));
                a  = (int'(tap_addr) < NT) ? int'(tap_addr) : 0;
                ci = h_i[hist_rd_addr];
                cq = h_q[hist_rd_addr];
                pr = longint'(cre[a]) * ci - longint'(cim[a]) * cq;
                pi = longint'(cre[a]) * cq + longint'(cim[a]) * ci;
                if (mac_clr) begin
                    acc_re = pr;
                    acc_im = pi;
                end else begin
                    acc_re += pr;
                    acc_im += pi;
                end
                mac_k++;
                if (mac_last) begin
                    res_re     = acc_re;
                    res_im     = acc_im;
                    mac_k      = 0;
                    last_mac_t = cyc;
                end
            end

            if (real_wr_en) begin
                chk("drain_gap_ok", longint'(cyc - last_mac_t >= ML + 1), 1);
                chk("out_count_at_write", out_count, wr_cnt);
                chk("pending_output", longint'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("y_real", res_re, e.re);
                    chk("y_imag", res_im, e.im);
                end
                wr_cnt++;
                last_wr_t = cyc;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        int pc, n, errs, base, extra;
        for (int k = 0; k < NT; k++) begin
            cre[k] = int'($urandom_range(0, 255)) - 128;
            cim[k] = int'($urandom_range(0, 255)) - 128;
        end
        rst = 1'b1;
        upd();
        repeat (3) tick();
        rst = 1'b0;

        // History zeroing after reset, then idle in LOAD.
        repeat (34) tick();
        chk("init_zero_writes", zero_cnt, HD);
        chk("idle_busy", busy, 0);
        chk("idle_no_pop", pop_cnt, 0);

        // Single pair: latency, read-address sequence, count.
        rd_log.delete();
        push_pair();
        wait_writes(1, 80, "first_output_written");
        chk("lat_pop_to_write", last_wr_t - last_pop_t, 1 + NT + ML);
        chk("rd_log_len", rd_log.size(), NT);
        errs = 0;
        for (int k = 0; k < NT && k < rd_log.size(); k++)
            if (rd_log[k] != (HD - k) % HD) errs++;
        chk("rd_seq_errs", errs, 0);
        tick();
        chk("out_count_1", out_count, 1);

        // Only the I FIFO has data: must not pop until Q also has data.
        q_allow = 1'b0;
        push_pair();
        pc = pop_cnt;
        repeat (10) tick();
        chk("no_single_pop", pop_cnt, pc);
        q_allow = 1'b1;
        upd();
        tick();
        chk("joint_pop", pop_cnt, pc + 1);
        wait_writes(2, 80, "second_output_written");

        // Real FIFO full during WRITE holds the strobe off.
        real_full = 1'b1;
        push_pair();
        pc = pop_cnt;
        n = 0;
        while (pop_cnt == pc && n < 20) begin
            tick();
            n++;
        end
        chk("stall_pop_seen", pop_cnt, pc + 1);
        repeat (1 + NT + ML + 5) tick();
        chk("stall_no_write", wr_cnt, 2);
        chk("stall_busy", busy, 1);
        real_full = 1'b0;
        repeat (2) tick();
        chk("stall_release", wr_cnt, 3);
        repeat (5) tick();
        chk("single_joint_write", wr_cnt, 3);
        chk("out_count_3", out_count, 3);

        // Continuous feed (wraps history) followed by randomized back-pressure and gaps.
        for (int i = 0; i < 40; i++) push_pair();
        extra = 0;
        for (int c = 0; c < 3000; c++) begin
            i_allow   = ($urandom_range(0, 3) != 0);
            q_allow   = ($urandom_range(0, 3) != 0);
            real_full = ($urandom_range(0, 3) == 0);
            imag_full = ($urandom_range(0, 3) == 0);
            if (extra < 30 && $urandom_range(0, 19) == 0) begin
                push_pair();
                extra++;
            end
            tick();
        end
        i_allow   = 1'b1;
        q_allow   = 1'b1;
        real_full = 1'b0;
        imag_full = 1'b0;
        upd();
        base = xi.size() / DEC;
        wait_writes(base, 80 * 40, "random_all_written");
        chk("random_exp_empty", exp_q.size(), 0);
        tick();
        chk("random_out_count", out_count, base);

        // Reset in the 7th MAC cycle abandons the output and re-zeroes history.
        push_pair();
        n = 0;
        while (!(mac_en && tap_addr == TW'(6)) && n < 60) begin
            tick();
            n++;
        end
        chk("reached_mac_cycle7", longint'(mac_en && tap_addr == TW'(6)), 1);
        rst = 1'b1;
        flush();
        tick();
        rst = 1'b0;
        repeat (34) tick();
        chk("reinit_zero_writes", zero_cnt, HD);
        chk("reinit_out_count", out_count, 0);
        chk("reinit_no_write", wr_cnt, 0);
        rd_log.delete();
        push_pair();
        wait_writes(1, 80, "post_reset_output");
        chk("post_reset_rd0", (rd_log.size() > 0) ? rd_log[0] : -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
